// File: rtl/seq_mult_if.sv
// Start/busy/done multiplier handshake bundle between the control unit and seq_mult.
// Latency: none. This is wiring only.
// Backpressure: none. busy tells the master that start is being ignored.
//
// Ports:
//   start     - master -> slave, operation request
//   is_signed - master -> slave, 1 = two's complement operands
//   a, b      - master -> slave, multiplicand and multiplier (WIDTH bits)
//   busy      - slave -> master, operation in flight
//   done      - slave -> master, one-cycle pulse when y is updated
//   y         - slave -> master, 2*WIDTH-bit product
interface seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     y;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, y
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, y
    );
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier for signed or unsigned operands with a full 2*WIDTH product.
// Latency: WIDTH+1 cycles from the start-sampling edge to done. Back-to-back period is WIDTH+2.
// Backpressure: start is ignored while busy. Requests are not queued.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_mult_if slave modport (start/is_signed/a/b in, busy/done/y out)
//           The interface WIDTH must equal this module's WIDTH.
module seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_a_q;
    logic [WIDTH-1:0]     mag_b_q;
    logic [WIDTH-1:0]     acc_hi_q;
    logic                 neg_q;
    logic [CW-1:0]        count_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   y_q;

    logic                 a_neg;
    logic                 b_neg;
    logic                 last_iter;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;

    assign a_neg     = bus.is_signed & bus.a[WIDTH-1];
    assign b_neg     = bus.is_signed & bus.b[WIDTH-1];
    assign last_iter = (count_q == CW'(WIDTH - 1));

    // The multiplier register doubles as the low half of the product. Each
    // iteration consumes its LSB and shifts in the adder's LSB from the top.
    assign sum  = {1'b0, acc_hi_q} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
    assign prod = {acc_hi_q, mag_b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_hi_q <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            y_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // The most negative value negates to itself. Read as
                        // unsigned, that pattern is the correct magnitude 2^(W-1).
                        mag_a_q  <= a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
                        mag_b_q  <= b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
                        neg_q    <= a_neg ^ b_neg;
                        acc_hi_q <= '0;
                        count_q  <= '0;
                    end
                end
                RUN: begin
                    acc_hi_q <= sum[WIDTH:1];
                    mag_b_q  <= {sum[0], mag_b_q[WIDTH-1:1]};
                    // This wraps to 0 on the last iteration when WIDTH is a
                    // power of two. That is harmless because RUN is leaving.
                    count_q  <= count_q + CW'(1);
                end
                FIX: begin
                    // Negating a zero magnitude gives zero, so a negative
                    // operand times zero yields a clean 0.
                    y_q    <= neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.y    = y_q;
endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    seq_mult_if #(.WIDTH(32)) bus32 ();
    seq_mult_if #(.WIDTH(8))  bus8 ();

    seq_mult #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    seq_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] y;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] ha [141];
    logic [31:0] hb [141];
    logic        hs [141];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference products from plain integer arithmetic
    function automatic logic [63:0] ref32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] ref8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 16'(sa * sb);
        end
        return {8'b0, a} * {8'b0, b};
    endfunction

    // Issue one op on the 32-bit unit. Return the product, the edges from start to done,
    // the busy-high cycles, and whether y held steady until done.
    task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] y, output int lat, output int busy_n,
                         output logic y_stable);
        logic [63:0] y0;
        @(negedge clk);
        y0              = bus32.y;
        bus32.start     = 1'b1;
        bus32.is_signed = sgn;
        bus32.a         = a;
        bus32.b         = b;
        @(posedge clk); #1;
        bus32.start     = 1'b0;
        bus32.a         = $urandom;
        bus32.b         = $urandom;
        bus32.is_signed = 1'($urandom_range(0, 1));
        lat      = -1;
        busy_n   = 0;
        y_stable = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            if (bus32.busy) busy_n++;
            @(posedge clk); #1;
            if (bus32.done) begin
                lat = k;
                break;
            end
            if (bus32.y !== y0) y_stable = 1'b0;
        end
        y = bus32.y;
    endtask

    task automatic run8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] y, output int lat);
        @(negedge clk);
        bus8.start     = 1'b1;
        bus8.is_signed = sgn;
        bus8.a         = a;
        bus8.b         = b;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = k;
                break;
            end
        end
        y = bus8.y;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] y;
        logic [15:0] y8;
        int          lat, busy_n, ndone;
        logic        y_stable, seen;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic        rs;

        vecs[0] = '{1'b1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{1'b1, 32'hFFFF_FFF9, 32'd0,         64'h0000_0000_0000_0000};
        vecs[6] = '{1'b0, 32'd0,         32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
        vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[8] = '{1'b0, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780};

        rst_n = 1'b0;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset busy", 64'(bus32.busy), 64'd0);
        check("reset done", 64'(bus32.done), 64'd0);
        check("reset y",    bus32.y,         64'd0);
        check("reset y8",   64'(bus8.y),     64'd0);

        // Directed vectors: product, latency, busy span, y hold and done width
        for (int i = 0; i < 9; i++) begin
            run32(vecs[i].sgn, vecs[i].a, vecs[i].b, y, lat, busy_n, y_stable);
            check($sformatf("vec%0d y", i),        y,              vecs[i].y);
            check($sformatf("vec%0d latency", i),  64'(lat),       64'd33);
            check($sformatf("vec%0d busy", i),     64'(busy_n),    64'd33);
            check($sformatf("vec%0d y hold", i),   64'(y_stable),  64'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d done width", i), 64'(bus32.done), 64'd0);
        end

        // start held high with operands changing every cycle. Ops should be accepted at
        // edges 0, 34, 68 and 102, and done should appear 33 edges later.
        ndone = 0;
        for (int n = 0; n < 141; n++) begin
            @(negedge clk);
            ha[n] = $urandom;
            hb[n] = $urandom;
            hs[n] = 1'($urandom_range(0, 1));
            bus32.start     = (n <= 102);
            bus32.a         = ha[n];
            bus32.b         = hb[n];
            bus32.is_signed = hs[n];
            @(posedge clk); #1;
            if (bus32.done) begin
                check($sformatf("hold done edge %0d", ndone), 64'(n), 64'(33 + 34 * ndone));
                if (n >= 33)
                    check($sformatf("hold y %0d", ndone), bus32.y, ref32(hs[n-33], ha[n-33], hb[n-33]));
                ndone++;
            end
        end
        check("hold done count", 64'(ndone), 64'd4);

        // Reset in the middle of RUN
        @(negedge clk);
        bus32.start = 1'b1; bus32.is_signed = 1'b0;
        bus32.a = 32'd1234; bus32.b = 32'd5678;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(bus32.busy), 64'd0);
        check("midrst done", 64'(bus32.done), 64'd0);
        check("midrst y",    bus32.y,         64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.done) seen = 1'b1;
        end
        check("midrst no done", 64'(seen), 64'd0);
        run32(1'b0, 32'd5, 32'd6, y, lat, busy_n, y_stable);
        check("post rst y",   y,        64'd30);
        check("post rst lat", 64'(lat), 64'd33);

        // Random 32-bit sweep
        for (int i = 0; i < 15; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            run32(rs, ra, rb, y, lat, busy_n, y_stable);
            check($sformatf("rnd32 %0d y", i), y, ref32(rs, ra, rb));
        end

        // 8-bit instance: most negative squared, then a random sweep
        run8(1'b1, 8'h80, 8'h80, y8, lat);
        check("w8 min*min y",   64'(y8),  64'h4000);
        check("w8 min*min lat", 64'(lat), 64'd9);
        for (int i = 0; i < 30; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom_range(0, 1));
            run8(rs, ra8, rb8, y8, lat);
            check($sformatf("rnd8 %0d y", i),   64'(y8),  64'(ref8(rs, ra8, rb8)));
            check($sformatf("rnd8 %0d lat", i), 64'(lat), 64'd9);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
